// File: rtl/simple_proc_sequencer.sv
// Instruction sequencer: buffers 32-bit instructions in a FIFO, issues them to an
// external 8-bit datapath, captures each result and offers it on a valid/ready port.
// Optional build macro SIMPLE_PROC_SEQ_ILLEGAL_TRAP_EN: drop unknown opcodes and pulse illegal_op.
module simple_proc_sequencer #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic [31:0]      alu_instr,
  input  logic [7:0]       alu_result,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level,
  output logic             illegal_op,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens at a rising edge where valid and ready are both 1
  // (in_valid/in_ready for instructions, out_valid/out_ready for results); flush voids both.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [31:0]      mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [31:0]      alu_instr_q;
  logic [7:0]       out_data_q;
  logic             out_valid_q;
  logic             illegal_q;

  logic        full, empty, push, pop, accept, head_legal;
  logic [31:0] head;

  assign head   = mem_q[rd_ptr_q];
  assign full   = (level_q == LVL_W'(DEPTH));
  assign empty  = (level_q == '0);
  assign push   = in_valid && !full && !flush;
  assign accept = (state_q == DONE) && out_ready;
  // A pop either starts an issue or, for a trapped opcode, silently discards the head.
  assign pop    = !flush && !empty && ((state_q == IDLE) || accept);

`ifdef SIMPLE_PROC_SEQ_ILLEGAL_TRAP_EN
  // Legal opcodes are 0x88..0x8B, i.e. the top six bits equal 6'b100010.
  assign head_legal = (head[31:26] == 6'b100010);
`else
  assign head_legal = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      alu_instr_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (push) begin
        mem_q[wr_ptr_q] <= in_instr;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      level_q <= level_q + LVL_W'(push) - LVL_W'(pop);

      if (flush) begin
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        level_q     <= '0;
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (pop) begin
              if (head_legal) begin
                alu_instr_q <= head;
                state_q     <= ISSUE;
              end else begin
                illegal_q <= 1'b1;
              end
            end
          end
          ISSUE: begin
            out_data_q  <= alu_result;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
          DONE: begin
            if (accept) begin
              out_valid_q <= 1'b0;
              if (pop && head_legal) begin
                alu_instr_q <= head;
                state_q     <= ISSUE;
              end else begin
                state_q   <= IDLE;
                illegal_q <= pop;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in_ready   = !full;
  assign alu_instr  = alu_instr_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = (state_q != IDLE) || !empty;
  assign fifo_level = level_q;
  assign illegal_op = illegal_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_simple_proc_sequencer.sv
// Self-checking bench for simple_proc_sequencer: directed vectors, expected-result
// queue filled by the driver, monitor pops and compares on each accepted result.
module tb_simple_proc_sequencer;

  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic [31:0]      alu_instr;
  logic [7:0]       alu_result;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_ready;
  logic             busy;
  logic [LVL_W-1:0] fifo_level;
  logic             illegal_op;
  logic [1:0]       state_dbg;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ill_cnt  = 0;

  simple_proc_sequencer #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .alu_instr  (alu_instr),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .fifo_level (fifo_level),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Environment datapath driven from the issued instruction.
  function automatic logic [7:0] alu_fn(input logic [31:0] ins);
    case (ins[31:24])
      8'h88:   return ins[7:0] + ins[15:8];
      8'h89:   return ins[7:0] - ins[15:8];
      8'h8A:   return ins[7:0] + 8'd1;
      default: return ins[7:0] - 8'd1;
    endcase
  endfunction
  assign alu_result = alu_fn(alu_instr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (illegal_op === 1'b1) ill_cnt++;
      check("level_bound", 32'(fifo_level <= LVL_W'(DEPTH)), 32'd1);
      if (out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check("result", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic push(input logic [31:0] ins, input logic [7:0] exp, input bit has_exp);
    int n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) check("push_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (has_exp) exp_q.push_back(exp);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(n < 2000), 32'd1);
  endtask

  logic [31:0] rv_ins [8] = '{32'h8800_7F01, 32'h8900_0100, 32'h8A00_00FF, 32'h8B00_0000,
                              32'h8800_8080, 32'h8900_1005, 32'h8B00_0001, 32'h8800_2211};
  logic [7:0]  rv_exp [8] = '{8'h80, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hF5, 8'h00, 8'h33};

  initial begin
    int cyc;
    bit done;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;

    // 1: reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_alu_instr", alu_instr, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // 2: single instruction latency and basic ops
    out_ready = 1'b1;
    push(32'h8800_0503, 8'h08, 1'b1);
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (out_valid) break;
    end
    check("latency_edges", 32'(cyc), 32'd3);
    wait_drain("drain_add");
    push(32'h8900_0503, 8'hFE, 1'b1);
    wait_drain("drain_sub");
    push(32'h8A00_00FF, 8'h00, 1'b1);
    wait_drain("drain_inc");

    // 3: backpressure with a full FIFO
    out_ready = 1'b0;
    push(32'h8800_1020, 8'h30, 1'b1);
    push(32'h8900_3010, 8'hE0, 1'b1);
    push(32'h8A00_007F, 8'h80, 1'b1);
    push(32'h8B00_0000, 8'hFF, 1'b1);
    push(32'h8800_FFFF, 8'hFE, 1'b1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_level", 32'(fifo_level), 32'd4);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_data", 32'(out_data), 32'h30);
    in_valid = 1'b1; in_instr = 32'h8800_0101;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    check("stall_data_held", 32'(out_data), 32'h30);
    check("full_level_held", 32'(fifo_level), 32'd4);
    out_ready = 1'b1;
    wait_drain("drain_full");

    // 4: flush in DONE with queued work and a concurrent push
    out_ready = 1'b0;
    push(32'h8800_0102, 8'h03, 1'b1);
    push(32'h8800_0304, 8'h07, 1'b1);
    push(32'h8800_0506, 8'h0B, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("pre_flush_valid", 32'(out_valid), 32'd1);
    check("pre_flush_level", 32'(fifo_level), 32'd2);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h8800_1111; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_level", 32'(fifo_level), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_alu_kept", alu_instr, 32'h8800_0102);
    push(32'h8B00_0010, 8'h0F, 1'b1);
    wait_drain("drain_flush");

    // 5: unknown opcode
    ill_cnt = 0;
`ifdef SIMPLE_PROC_SEQ_ILLEGAL_TRAP_EN
    push(32'h4200_0010, 8'h00, 1'b0);
    push(32'h8800_0101, 8'h02, 1'b1);
    wait_drain("drain_illegal");
    check("illegal_pulses", 32'(ill_cnt), 32'd1);
`else
    push(32'h4200_0010, 8'h0F, 1'b1);
    push(32'h8800_0101, 8'h02, 1'b1);
    wait_drain("drain_unknown");
    check("illegal_pulses", 32'(ill_cnt), 32'd0);
`endif

    // 6: vectors under random consumer stalls
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) push(rv_ins[i], rv_exp[i], 1'b1);
        out_ready = 1'b1;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("drain_random");

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_level", 32'(fifo_level), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
